// File: rtl/uart_io_ctrl.sv
// Bridges the CPU serial ports and the UART: an RX FIFO behind an irr/ack handshake,
// and a round-robin CPU/debug arbiter that sequences each byte against the UART busy flag.
module uart_io_ctrl #(
   parameter int RX_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       irr,
   input  logic       ack,
   output logic [7:0] rx_data,
   output logic       rx_overrun,
   input  logic       rx_overrun_clr,
   input  logic       cpu_tx_req,
   input  logic [7:0] cpu_tx_data,
   output logic       tx_busy,
   input  logic       dbg_tx_req,
   input  logic [7:0] dbg_tx_data,
   output logic       dbg_busy,
   output logic       uart_tx_start,
   output logic [7:0] uart_tx_data,
   input  logic       uart_tx_busy
);

   localparam int AW = $clog2(RX_DEPTH);
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

   logic [7:0]    mem [RX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   logic          ack_q, pop, push, full;

   assign full    = (count == (AW+1)'(RX_DEPTH));
   assign pop     = ack & ~ack_q & (count != '0);
   // A simultaneous pop frees the slot, so a full FIFO can still accept
   assign push    = rx_valid & (~full | pop);
   assign rx_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (push & ~pop)
         count_next = count + (AW+1)'(1);
      else if (pop & ~push)
         count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RX_DEPTH; i++)
            mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ack_q      <= 1'b0;
         irr        <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         ack_q <= ack;
         count <= count_next;
         irr   <= (count_next != '0) & ~ack;
         if (push) begin
            mem[wr_ptr] <= rx_byte;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (rx_valid & full & ~pop)
            rx_overrun <= 1'b1;
         else if (rx_overrun_clr)
            rx_overrun <= 1'b0;
      end
   end

   state_t     state, state_next;
   logic       owner, last_owner;
   logic       cpu_req_q, dbg_req_q, cpu_pend, dbg_pend;
   logic [7:0] cpu_byte, dbg_byte;
   logic       grant, grant_dbg, cpu_active, dbg_active, cpu_set, dbg_set;

   assign cpu_active = (state != IDLE) & (owner == OWN_CPU);
   assign dbg_active = (state != IDLE) & (owner == OWN_DBG);
   assign cpu_set    = cpu_tx_req & ~cpu_req_q & ~cpu_pend & ~cpu_active;
   assign dbg_set    = dbg_tx_req & ~dbg_req_q & ~dbg_pend & ~dbg_active;
   assign tx_busy    = cpu_pend | cpu_active;
   assign dbg_busy   = dbg_pend | dbg_active;

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_dbg  = 1'b0;
      case (state)
         IDLE: begin
            if ((cpu_pend | dbg_pend) & ~uart_tx_busy) begin
               grant      = 1'b1;
               grant_dbg  = dbg_pend & (~cpu_pend | (last_owner == OWN_CPU));
               state_next = START;
            end
         end
         START:   state_next = WAIT_HI;
         WAIT_HI: if (uart_tx_busy)  state_next = WAIT_LO;
         WAIT_LO: if (!uart_tx_busy) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Start pulse is registered so it lands two cycles after the request edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         owner         <= OWN_CPU;
         last_owner    <= OWN_DBG;
         cpu_req_q     <= 1'b0;
         dbg_req_q     <= 1'b0;
         cpu_pend      <= 1'b0;
         dbg_pend      <= 1'b0;
         cpu_byte      <= '0;
         dbg_byte      <= '0;
         uart_tx_data  <= '0;
         uart_tx_start <= 1'b0;
      end else begin
         state         <= state_next;
         cpu_req_q     <= cpu_tx_req;
         dbg_req_q     <= dbg_tx_req;
         uart_tx_start <= (state == START);
         if (cpu_set) begin
            cpu_pend <= 1'b1;
            cpu_byte <= cpu_tx_data;
         end else if (grant & ~grant_dbg) begin
            cpu_pend <= 1'b0;
         end
         if (dbg_set) begin
            dbg_pend <= 1'b1;
            dbg_byte <= dbg_tx_data;
         end else if (grant & grant_dbg) begin
            dbg_pend <= 1'b0;
         end
         if (grant) begin
            owner        <= grant_dbg ? OWN_DBG : OWN_CPU;
            last_owner   <= grant_dbg ? OWN_DBG : OWN_CPU;
            uart_tx_data <= grant_dbg ? dbg_byte : cpu_byte;
         end
      end
   end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Bench for uart_io_ctrl: directed RX/TX scenarios plus random RX traffic against a queue model
// and random TX arbitration rounds against an expected-order list.
module tb_uart_io_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = '0;
   logic       irr;
   logic       ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_overrun;
   logic       rx_overrun_clr = 1'b0;
   logic       cpu_tx_req = 1'b0;
   logic [7:0] cpu_tx_data = '0;
   logic       tx_busy;
   logic       dbg_tx_req = 1'b0;
   logic [7:0] dbg_tx_data = '0;
   logic       dbg_busy;
   logic       uart_tx_start;
   logic [7:0] uart_tx_data;
   logic       uart_tx_busy = 1'b0;

   always #5 clk = ~clk;

   uart_io_ctrl #(.RX_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .irr(irr), .ack(ack),
      .rx_data(rx_data), .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr),
      .cpu_tx_req(cpu_tx_req), .cpu_tx_data(cpu_tx_data), .tx_busy(tx_busy),
      .dbg_tx_req(dbg_tx_req), .dbg_tx_data(dbg_tx_data), .dbg_busy(dbg_busy),
      .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RX reference: a byte queue of at most 8 entries plus the handshake flags
   logic [7:0] mq[$];
   bit m_ovr, m_ackq, m_irr, m_pop, m_full;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         mq.delete();
         m_ovr = 0; m_ackq = 0; m_irr = 0;
      end else begin
         m_pop  = ack && !m_ackq && mq.size() != 0;
         m_full = mq.size() == 8;
         if (m_pop) void'(mq.pop_front());
         if (rx_valid && (!m_full || m_pop)) mq.push_back(rx_byte);
         if (rx_valid && m_full && !m_pop) m_ovr = 1;
         else if (rx_overrun_clr) m_ovr = 0;
         m_ackq = ack;
         m_irr  = mq.size() != 0 && !ack;
      end
   end

   // UART transmitter model: logs start pulses, raises busy a cycle later for busy_len cycles
   logic [7:0] starts[$];
   int busy_len = 3;

   initial forever begin
      @(negedge clk);
      if (uart_tx_start === 1'b1) starts.push_back(uart_tx_data);
   end

   initial forever begin
      logic [7:0] b;
      @(negedge clk);
      if (uart_tx_start === 1'b1) begin
         b = uart_tx_data;
         @(negedge clk);
         uart_tx_busy = 1'b1;
         repeat (busy_len) @(negedge clk);
         if (tx_busy || dbg_busy) check("tx_data_hold", uart_tx_data, b);
         uart_tx_busy = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push(input logic [7:0] b);
      @(negedge clk); rx_valid = 1'b1; rx_byte = b;
      @(negedge clk); rx_valid = 1'b0;
   endtask

   task automatic ack_pulse();
      @(negedge clk); ack = 1'b1;
      @(negedge clk); check("irr_during_ack", irr, 0); ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmp_model();
      check("m_irr", irr, m_irr);
      if (m_irr) check("m_rx_data", rx_data, mq[0]);
      check("m_ovr", rx_overrun, m_ovr);
   endtask

   task automatic tx_req(input bit c, input bit d, input logic [7:0] cb, input logic [7:0] db);
      @(negedge clk);
      cpu_tx_req = c; cpu_tx_data = cb; dbg_tx_req = d; dbg_tx_data = db;
      @(negedge clk);
      cpu_tx_req = 1'b0; dbg_tx_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while ((tx_busy || dbg_busy || uart_tx_busy) && n < 300) begin
         @(negedge clk); n++;
      end
      if (n >= 300) check("wait_idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_busy(input logic lvl);
      int n;
      n = 0;
      while (uart_tx_busy !== lvl && n < 100) begin
         @(negedge clk); n++;
      end
      if (n >= 100) check("wait_busy_timeout", 1, 0);
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] drain_exp[8];
   bit m_last;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_irr", irr, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_ovr", rx_overrun, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_dbg_busy", dbg_busy, 0);
      check("rst_start", uart_tx_start, 0);
      check("rst_tx_data", uart_tx_data, 0);
      reset = 1'b1;
      @(negedge clk);

      // Three bytes in, then acknowledge them one by one
      push(8'h11); push(8'h22); push(8'h33);
      @(negedge clk);
      check("t1_irr", irr, 1);
      check("t1_data0", rx_data, 8'h11);
      ack_pulse();
      check("t1_data1", rx_data, 8'h22);
      check("t1_irr1", irr, 1);
      ack_pulse();
      check("t1_data2", rx_data, 8'h33);
      ack_pulse();
      check("t1_irr_empty", irr, 0);

      // Overflow, then clear racing against another drop
      for (int i = 1; i <= 9; i++) push(8'(i));
      @(negedge clk);
      check("t2_ovr", rx_overrun, 1);
      check("t2_head", rx_data, 8'h01);
      @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h0A; rx_overrun_clr = 1'b1;
      @(negedge clk); rx_valid = 1'b0; rx_overrun_clr = 1'b0;
      check("t2_set_wins", rx_overrun, 1);
      @(negedge clk); rx_overrun_clr = 1'b1;
      @(negedge clk); rx_overrun_clr = 1'b0;
      check("t2_clr", rx_overrun, 0);

      // Full FIFO: push together with a pop is accepted
      @(negedge clk); ack = 1'b1; rx_valid = 1'b1; rx_byte = 8'h0B;
      @(negedge clk); rx_valid = 1'b0; ack = 1'b0;
      check("t3_no_ovr", rx_overrun, 0);
      check("t3_head", rx_data, 8'h02);
      @(negedge clk);
      drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0B};
      for (int i = 0; i < 8; i++) begin
         check("t3_drain", rx_data, drain_exp[i]);
         ack_pulse();
      end
      check("t3_empty", irr, 0);
      cmp_model();

      // Random RX traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cmp_model();
         rx_valid       = ($urandom_range(0, 2) == 0);
         rx_byte        = 8'($urandom);
         ack            = ($urandom_range(0, 3) == 0);
         rx_overrun_clr = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      rx_valid = 1'b0; ack = 1'b0; rx_overrun_clr = 1'b0;
      for (int i = 0; i < 12 && mq.size() != 0; i++) ack_pulse();
      cmp_model();
      check("rand_drained", irr, 0);

      // Simultaneous CPU and debug requests, twice
      busy_len = 3;
      starts.delete();
      tx_req(1, 1, 8'h41, 8'h42); wait_idle();
      tx_req(1, 1, 8'h43, 8'h44); wait_idle();
      check("t4_count", starts.size(), 4);
      if (starts.size() == 4) begin
         check("t4_s0", starts[0], 8'h41);
         check("t4_s1", starts[1], 8'h42);
         check("t4_s2", starts[2], 8'h43);
         check("t4_s3", starts[3], 8'h44);
      end

      // Long busy; a second CPU edge while the UART is busy must be dropped
      busy_len = 20;
      starts.delete();
      @(negedge clk); cpu_tx_req = 1'b1; cpu_tx_data = 8'h55;
      repeat (3) @(negedge clk);
      check("t5_start_latency", uart_tx_start, 1);
      check("t5_start_data", uart_tx_data, 8'h55);
      cpu_tx_req = 1'b0;
      wait_busy(1'b1);
      repeat (5) @(negedge clk);
      check("t5_tx_busy", tx_busy, 1);
      check("t5_dbg_busy", dbg_busy, 0);
      cpu_tx_req = 1'b1; cpu_tx_data = 8'h56;
      @(negedge clk); cpu_tx_req = 1'b0;
      check("t5_tx_busy2", tx_busy, 1);
      wait_busy(1'b0);
      repeat (2) @(negedge clk);
      check("t5_tx_idle", tx_busy, 0);
      repeat (10) @(negedge clk);
      check("t5_one_start", starts.size(), 1);

      // Reset in the middle of a transfer
      starts.delete();
      push(8'h77);
      tx_req(1, 0, 8'h66, 8'h00);
      wait_busy(1'b1);
      repeat (3) @(negedge clk);
      check("t6_pre_irr", irr, 1);
      check("t6_pre_busy", tx_busy, 1);
      reset = 1'b0;
      #1;
      check("t6_irr", irr, 0);
      check("t6_tx_busy", tx_busy, 0);
      check("t6_dbg_busy", dbg_busy, 0);
      check("t6_start", uart_tx_start, 0);
      @(negedge clk); reset = 1'b1;
      wait_idle();
      check("t6_fifo_empty", irr, 0);
      check("t6_no_restart", starts.size(), 1);
      push(8'h88);
      @(negedge clk);
      check("t6_new_head", rx_data, 8'h88);
      ack_pulse();

      // Random arbitration rounds; last owner after reset is debug
      busy_len = 2;
      starts.delete();
      exp_q.delete();
      m_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bit c, d;
         logic [7:0] cb, db;
         c  = 1'($urandom);
         d  = 1'($urandom);
         if (!c && !d) c = 1'b1;
         cb = 8'($urandom);
         db = 8'($urandom);
         if (c && d) begin
            if (m_last) begin exp_q.push_back(cb); exp_q.push_back(db); end
            else        begin exp_q.push_back(db); exp_q.push_back(cb); end
         end else if (c) begin
            exp_q.push_back(cb); m_last = 1'b0;
         end else begin
            exp_q.push_back(db); m_last = 1'b1;
         end
         tx_req(c, d, cb, db);
         wait_idle();
      end
      check("t7_count", starts.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < starts.size(); i++)
         check("t7_order", starts[i], exp_q[i]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
